// File: rtl/vt_cursor_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vt_cursor_gen                                              |
// | Description : Cursor overlay, frame-synchronous cursor/character blink   |
// |               timing and bell tone generator. Consumes the cursor        |
// |               address and the cursor/bell control bits of VTCSR and      |
// |               feeds the character raster generator.                      |
// | Ports       : wb_clk_i   - system clock                                  |
// |               wb_rst_n   - asynchronous active-low reset                 |
// |               cursor_i   - cursor address (latched on frame_i)           |
// |               cur_en_i   - cursor displayed                              |
// |               cur_blk_i  - 0 = underline cursor, 1 = block cursor        |
// |               bell_i     - bell request level (rising edge rings)        |
// |               frame_i    - one-clock pulse at start of vertical blank    |
// |               chr_vld_i  - raster cycle addresses a visible character    |
// |               chr_adr_i  - address of the character being scanned        |
// |               row_i      - scan row within the character cell            |
// |               cur_pix_o  - registered cursor overlay for this cell row    |
// |               blink_o    - character blink phase (1 = visible)           |
// |               bell_o     - bell square wave                              |
// |               bell_act_o - bell in progress                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vt_cursor_gen #(
  parameter int CELL_ROWS   = 12,
  parameter int UL_ROW      = 10,
  parameter int CUR_FRAMES  = 16,
  parameter int CHR_FRAMES  = 32,
  parameter int BELL_HALF   = 12500,
  parameter int BELL_FRAMES = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic [10:0] cursor_i,
  input  logic        cur_en_i,
  input  logic        cur_blk_i,
  input  logic        bell_i,
  input  logic        frame_i,
  input  logic        chr_vld_i,
  input  logic [10:0] chr_adr_i,
  input  logic [3:0]  row_i,
  output logic        cur_pix_o,
  output logic        blink_o,
  output logic        bell_o,
  output logic        bell_act_o
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RING = 1'b1;

  localparam int TONE_W = (BELL_HALF > 1) ? $clog2(BELL_HALF) : 1;
  localparam int DUR_W  = (BELL_FRAMES > 0) ? $clog2(BELL_FRAMES + 1) : 1;

  localparam logic [4:0]        c_CUR_LAST  = 5'(CUR_FRAMES - 1);
  localparam logic [5:0]        c_CHR_LAST  = 6'(CHR_FRAMES - 1);
  localparam logic [4:0]        c_CELL_ROWS = 5'(CELL_ROWS);
  localparam logic [4:0]        c_UL_ROW    = 5'(UL_ROW);
  localparam logic [TONE_W-1:0] c_TONE_LAST = TONE_W'(BELL_HALF - 1);
  localparam logic [DUR_W-1:0]  c_DUR_LOAD  = DUR_W'(BELL_FRAMES);
  localparam logic [DUR_W-1:0]  c_DUR_ONE   = DUR_W'(1);

  logic [10:0]       r_cur_lat;
  logic [4:0]        r_cur_cnt;
  logic [5:0]        r_chr_cnt;
  logic              r_cur_ph;
  logic              r_blink;
  logic              r_cur_pix;
  logic              r_bell;
  logic              r_bell_q;
  logic              r_bell_rise;
  logic [0:0]        r_state;
  logic [DUR_W-1:0]  r_dur_cnt;
  logic [TONE_W-1:0] r_tone_cnt;

  logic w_cur_moved;
  logic w_row_sel;

  assign w_cur_moved = (cursor_i != r_cur_lat);

  // Block cursor covers every real row; underline only the bottom rows.
  // Rows beyond the cell height never select in either shape.
  assign w_row_sel = ({1'b0, row_i} < c_CELL_ROWS) &&
                     (cur_blk_i || ({1'b0, row_i} >= c_UL_ROW));

  // Cursor latch and cursor blink. A moved cursor restarts the blink so
  // it is visible right away; the restart overrides the normal count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_cur_lat <= '0;
      r_cur_cnt <= '0;
      r_cur_ph  <= 1'b1;
    end else if (frame_i) begin
      r_cur_lat <= cursor_i;
      if (w_cur_moved) begin
        r_cur_cnt <= '0;
        r_cur_ph  <= 1'b1;
      end else if (r_cur_cnt == c_CUR_LAST) begin
        r_cur_cnt <= '0;
        r_cur_ph  <= ~r_cur_ph;
      end else begin
        r_cur_cnt <= r_cur_cnt + 5'd1;
      end
    end
  end

  // Character blink, independent of cursor moves.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_chr_cnt <= '0;
      r_blink   <= 1'b1;
    end else if (frame_i) begin
      if (r_chr_cnt == c_CHR_LAST) begin
        r_chr_cnt <= '0;
        r_blink   <= ~r_blink;
      end else begin
        r_chr_cnt <= r_chr_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_cur_pix <= 1'b0;
    end else begin
      r_cur_pix <= chr_vld_i & cur_en_i & r_cur_ph &
                   (chr_adr_i == r_cur_lat) & w_row_sel;
    end
  end

  // The detected edge is registered so the FSM reacts two clocks after
  // bell_i rises (one to sample bell_i, one to enter RING).
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_bell_q    <= 1'b0;
      r_bell_rise <= 1'b0;
    end else begin
      r_bell_q    <= bell_i;
      r_bell_rise <= bell_i & ~r_bell_q;
    end
  end

  // Bell FSM. A fresh edge restarts duration and tone and takes priority
  // over a same-cycle frame decrement or expiry.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= c_IDLE;
      r_dur_cnt  <= '0;
      r_tone_cnt <= '0;
      r_bell     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (r_bell_rise) begin
            r_state    <= c_RING;
            r_dur_cnt  <= c_DUR_LOAD;
            r_tone_cnt <= '0;
            r_bell     <= 1'b1;
          end
        end
        c_RING: begin
          if (r_bell_rise) begin
            r_dur_cnt  <= c_DUR_LOAD;
            r_tone_cnt <= '0;
            r_bell     <= 1'b1;
          end else if (frame_i && (r_dur_cnt <= c_DUR_ONE)) begin
            r_state    <= c_IDLE;
            r_dur_cnt  <= '0;
            r_tone_cnt <= '0;
            r_bell     <= 1'b0;
          end else begin
            if (frame_i) begin
              r_dur_cnt <= r_dur_cnt - c_DUR_ONE;
            end
            if (r_tone_cnt == c_TONE_LAST) begin
              r_tone_cnt <= '0;
              r_bell     <= ~r_bell;
            end else begin
              r_tone_cnt <= r_tone_cnt + TONE_W'(1);
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_bell  <= 1'b0;
        end
      endcase
    end
  end

  assign cur_pix_o  = r_cur_pix;
  assign blink_o    = r_blink;
  assign bell_o     = r_bell;
  assign bell_act_o = (r_state == c_RING);

endmodule
`default_nettype wire

// File: tb/tb_vt_cursor_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vt_cursor_gen                                           |
// | Description : Self-checking bench for vt_cursor_gen. A frame-count       |
// |               based reference model predicts every output each clock.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vt_cursor_gen;

  localparam int CR  = 12;
  localparam int UL  = 10;
  localparam int CF  = 16;
  localparam int CHF = 32;
  localparam int BH  = 4;
  localparam int BF  = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] cursor_i;
  logic        cur_en_i;
  logic        cur_blk_i;
  logic        bell_i;
  logic        frame_i;
  logic        chr_vld_i;
  logic [10:0] chr_adr_i;
  logic [3:0]  row_i;
  logic        cur_pix_o;
  logic        blink_o;
  logic        bell_o;
  logic        bell_act_o;

  always #5 clk = ~clk;

  vt_cursor_gen #(
    .CELL_ROWS  (CR),
    .UL_ROW     (UL),
    .CUR_FRAMES (CF),
    .CHR_FRAMES (CHF),
    .BELL_HALF  (BH),
    .BELL_FRAMES(BF)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .cursor_i  (cursor_i),
    .cur_en_i  (cur_en_i),
    .cur_blk_i (cur_blk_i),
    .bell_i    (bell_i),
    .frame_i   (frame_i),
    .chr_vld_i (chr_vld_i),
    .chr_adr_i (chr_adr_i),
    .row_i     (row_i),
    .cur_pix_o (cur_pix_o),
    .blink_o   (blink_o),
    .bell_o    (bell_o),
    .bell_act_o(bell_act_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: cursor/character phases derive from frame counts,
  // the bell from frames remaining and clocks elapsed since it started.
  int   m_lat;
  int   m_cur_frames;
  int   m_chr_frames;
  logic m_pix;
  logic m_bell_prev;
  logic m_rise_pend;
  logic m_ring;
  int   m_left;
  int   m_clks;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_lat        = 0;
    m_cur_frames = 0;
    m_chr_frames = 0;
    m_pix        = 1'b0;
    m_bell_prev  = 1'b0;
    m_rise_pend  = 1'b0;
    m_ring       = 1'b0;
    m_left       = 0;
    m_clks       = 0;
  endfunction

  // One clock: advance the model with the applied inputs, clock, check.
  task automatic tick();
    logic ph;
    logic rowsel;
    ph     = ((m_cur_frames / CF) % 2) == 0;
    rowsel = (int'(row_i) < CR) && (cur_blk_i || int'(row_i) >= UL);
    m_pix  = chr_vld_i && cur_en_i && ph && (int'(chr_adr_i) == m_lat) && rowsel;
    if (frame_i) begin
      if (int'(cursor_i) != m_lat) begin
        m_lat        = int'(cursor_i);
        m_cur_frames = 0;
      end else begin
        m_cur_frames++;
      end
      m_chr_frames++;
    end
    if (m_rise_pend) begin
      m_ring = 1'b1;
      m_left = BF;
      m_clks = 0;
    end else if (m_ring) begin
      if (frame_i) m_left--;
      if (m_left == 0) m_ring = 1'b0;
      else m_clks++;
    end
    m_rise_pend = bell_i && !m_bell_prev;
    m_bell_prev = bell_i;
    @(posedge clk);
    #1;
    chk("cur_pix", cur_pix_o, m_pix);
    chk("blink", blink_o, ((m_chr_frames / CHF) % 2) == 0);
    chk("bell_act", bell_act_o, m_ring);
    chk("bell_o", bell_o, m_ring && ((m_clks / BH) % 2) == 0);
    frame_i = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_cur_pix", cur_pix_o, 1'b0);
    chk("rst_blink", blink_o, 1'b1);
    chk("rst_bell_o", bell_o, 1'b0);
    chk("rst_bell_act", bell_act_o, 1'b0);
    model_reset();
    bell_i  = 1'b0;
    frame_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_cycle(input logic frm);
    int sel;
    chr_vld_i = ($urandom_range(0, 7) != 0);
    cur_en_i  = ($urandom_range(0, 3) != 0);
    cur_blk_i = 1'($urandom_range(0, 1));
    sel       = int'($urandom_range(0, 3));
    if (sel == 0)      chr_adr_i = 11'(m_lat);
    else if (sel == 1) chr_adr_i = cursor_i;
    else               chr_adr_i = 11'($urandom_range(0, 2047));
    row_i   = 4'($urandom_range(0, 15));
    frame_i = frm;
    tick();
  endtask

  task automatic run_frames(input int n, input int lines);
    for (int f = 0; f < n; f++) begin
      for (int l = 0; l < lines; l++) rand_cycle(1'b0);
      rand_cycle(1'b1);
    end
  endtask

  initial begin
    int ones;
    cursor_i  = 11'd0;
    cur_en_i  = 1'b1;
    cur_blk_i = 1'b0;
    bell_i    = 1'b0;
    frame_i   = 1'b0;
    chr_vld_i = 1'b0;
    chr_adr_i = 11'd0;
    row_i     = 4'd0;
    model_reset();
    #1;
    apply_reset();

    // Full-screen scan before any frame: underline at address 0 only.
    ones = 0;
    for (int a = 0; a < 1920; a++) begin
      for (int r = 0; r < CR; r++) begin
        chr_vld_i = 1'b1;
        chr_adr_i = 11'(a);
        row_i     = 4'(r);
        tick();
        if (cur_pix_o) ones++;
      end
    end
    chki("scan_ones", ones, 2);

    // 20 frames puts the cursor phase in its off half.
    run_frames(20, 8);

    // Move the cursor mid-frame; old position is still the latched one.
    cursor_i = 11'd80;
    for (int i = 0; i < 8; i++) rand_cycle(1'b0);
    chr_vld_i = 1'b1; cur_en_i = 1'b1; cur_blk_i = 1'b1;
    chr_adr_i = 11'd80; row_i = 4'd0; frame_i = 1'b1;
    tick();
    chk("move_frame_cycle", cur_pix_o, 1'b0);
    chr_adr_i = 11'd80;
    tick();
    chk("move_visible", cur_pix_o, 1'b1);

    // Blink over 64 frames with a static cursor.
    run_frames(64, 6);

    // Block cursor at a fresh position: rows 0..11 on, 12..15 off.
    cursor_i = 11'd200; chr_vld_i = 1'b0; frame_i = 1'b1;
    tick();
    ones = 0;
    for (int r = 0; r < 16; r++) begin
      chr_vld_i = 1'b1; cur_en_i = 1'b1; cur_blk_i = 1'b1;
      chr_adr_i = 11'd200; row_i = 4'(r);
      tick();
      if (cur_pix_o) ones++;
    end
    chki("block_rows", ones, CR);

    // Bell: two-clock latency, then 3 frames; held level does not retrigger.
    chr_vld_i = 1'b0;
    bell_i = 1'b1;
    tick();
    chk("bell_lat1", bell_act_o, 1'b0);
    tick();
    chk("bell_lat2", bell_act_o, 1'b1);
    chk("bell_lat2_tone", bell_o, 1'b1);
    run_frames(5, 12);
    chk("no_retrigger", bell_act_o, 1'b0);
    bell_i = 1'b0;
    for (int i = 0; i < 3; i++) rand_cycle(1'b0);

    // Rising edge coincident with the final frame extends the ring.
    bell_i = 1'b1;
    tick();
    tick();
    bell_i = 1'b0;
    run_frames(2, 10);
    for (int i = 0; i < 5; i++) rand_cycle(1'b0);
    bell_i = 1'b1;
    rand_cycle(1'b0);
    rand_cycle(1'b1);
    chk("collide_extend", bell_act_o, 1'b1);
    bell_i = 1'b0;
    run_frames(2, 10);
    chk("collide_hold", bell_act_o, 1'b1);
    run_frames(1, 10);
    chk("collide_end", bell_act_o, 1'b0);

    // Reset mid-ring silences the bell asynchronously.
    bell_i = 1'b1;
    for (int i = 0; i < 4; i++) rand_cycle(1'b0);
    chk("pre_reset_ring", bell_act_o, 1'b1);
    apply_reset();
    run_frames(3, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vt_cursor_gen.md
# vt_cursor_gen

Display-side consumer of the terminal control registers: takes the cursor address and the cursor/bell bits of VTCSR and turns them into per-character cursor overlay, frame-synchronous blink timing and an audible bell tone. Sits between the register block and the character raster generator; its `blink_o` output is the source the firmware samples and mirrors into VTCSR D5.

## Interface

**Parameters**
- `CELL_ROWS`, default 12: scan rows per character cell; rows are 0..CELL_ROWS-1.
- `UL_ROW`, default 10: first row of the underline cursor.
- `CUR_FRAMES`, default 16: frames per cursor blink half-period.
- `CHR_FRAMES`, default 32: frames per character blink half-period.
- `BELL_HALF`, default 12500: clocks per bell tone half-period.
- `BELL_FRAMES`, default 10: bell duration in frames.

**Ports**
- `wb_clk_i`, in, 1: system clock, shared with the bus.
- `wb_rst_n`, in, 1: reset, asynchronous, active-low.
- `cursor_i`, in, 11: cursor address.
- `cur_en_i`, in, 1: VTCSR D2. 1 = cursor displayed.
- `cur_blk_i`, in, 1: VTCSR D3. 0 = underline, 1 = block.
- `bell_i`, in, 1: VTCSR D4, bell request level.
- `frame_i`, in, 1: one-clock pulse at start of vertical blank.
- `chr_vld_i`, in, 1: the current raster cycle addresses a visible character.
- `chr_adr_i`, in, 11: address of the character being scanned.
- `row_i`, in, 4: scan row within the cell.
- `cur_pix_o`, out, 1: invert or overlay the current cell row (registered).
- `blink_o`, out, 1: character blink phase. 1 = blinking characters visible.
- `bell_o`, out, 1: bell square wave.
- `bell_act_o`, out, 1: bell in progress.

## Operation

- **Cursor latch**
  - `cur_lat` loads `cursor_i` only on `frame_i`, so there is no mid-frame tearing.
  - If the loaded value differs from the old `cur_lat`: the cursor blink counter is cleared and `cur_ph` is set to 1 (a moved cursor is shown immediately).
- **Cursor blink**
  - `cur_cnt` (5 bits) increments on each `frame_i`.
  - On reaching CUR_FRAMES-1 it wraps to 0 and toggles `cur_ph`.
  - A restart caused by a cursor move overrides the increment/toggle in the same cycle.
- **Character blink**
  - `chr_cnt` (6 bits) increments on each `frame_i`.
  - On reaching CHR_FRAMES-1 it wraps to 0 and toggles `blink_o`.
  - It is unaffected by cursor moves.
- **Overlay**
  - `cur_pix_o` is registered each clock as the AND of:
    - `chr_vld_i`
    - `cur_en_i`
    - `cur_ph`
    - `chr_adr_i == cur_lat` (full 11-bit compare)
    - row select: `cur_blk_i`, or `row_i` in UL_ROW..CELL_ROWS-1.
  - `row_i` >= CELL_ROWS never selects.
- **Bell FSM**, states IDLE and RING:
  - `bell_q` is `bell_i` registered; the rising edge is `bell_i & ~bell_q`.
  - IDLE to RING on a rising edge:
    - `dur_cnt` loads BELL_FRAMES.
    - `tone_cnt` loads 0.
    - `bell_o` is set to 1.
  - In RING:
    - `tone_cnt` counts 0..BELL_HALF-1; at the wrap `bell_o` toggles.
    - `frame_i` decrements `dur_cnt`.
    - When `dur_cnt` reaches 0: go to IDLE, `bell_o` = 0.
  - A rising edge in RING restarts duration and tone. This restart beats a same-cycle decrement or expiry.
  - A held-high `bell_i` does not retrigger. Firmware must clear D4 before ringing again.
- `bell_act_o` is 1 exactly in RING.

## Timing

- **Reset values**, applied asynchronously while `wb_rst_n` is 0:

  | Signal | Reset value |
  |---|---|
  | `cur_lat` | 0 |
  | `cur_cnt` | 0 |
  | `chr_cnt` | 0 |
  | `cur_ph` | 1 |
  | `blink_o` | 1 |
  | `cur_pix_o` | 0 |
  | `bell_o` | 0 |
  | `bell_act_o` | 0 |
  | `bell_q` | 0 |
  | FSM state | IDLE |

- Reset release mid-frame: the first `frame_i` latches the cursor and counts as frame 1 of both blink counters.
- Reset asserted mid-ring: the bell is silenced immediately.
- **Overlay latency**: 1 clock from `chr_adr_i`/`row_i`/`chr_vld_i` to `cur_pix_o`. `cur_en_i` and `cur_blk_i` are combinational into that register, so they also take effect with 1 clock.
- **Cursor move visibility**: first frame after the write; `cur_pix_o` can be asserted starting 1 clock after that `frame_i` cycle.
- **Bell**:
  - `bell_o`/`bell_act_o` rise 2 clocks after `bell_i` rises: 1 clock to register `bell_i`, 1 clock to enter RING.
  - Tone period is 2*BELL_HALF clocks.
  - Duration is BELL_FRAMES `frame_i` pulses.
  - Both outputs fall in the clock after the final `frame_i`.
- **Blink**:
  - `blink_o` toggles every CHR_FRAMES frames.
  - `cur_ph` toggles every CUR_FRAMES frames.
  - Both toggle in the clock following the `frame_i` that completes the count.

## Test plan

- **Reset / idle overlay**: reset, then scan `chr_adr_i` 0..1919 × rows 0..11 with `cur_en_i`=1, `cur_blk_i`=0, `cursor_i`=0 before the first `frame_i`.
  - `cur_pix_o`=1 only for address 0, rows 10 and 11, each 1 clock later.
- **Cursor move**: `cursor_i`=80 mid-frame.
  - Still drawn at 0 until `frame_i`, then at 80.
  - `cur_ph`=1 and blink count restarts even if the old phase was 0.
- **Blink**: 64 frames, cursor static.
  - `cur_ph` toggles at frames 16/32/48/64.
  - `blink_o` toggles at frames 32/64.
  - `cur_en_i`=0 forces `cur_pix_o`=0.
- **Block shape and row bound**: `cur_blk_i`=1.
  - Rows 0..11 of the cursor cell are all asserted.
  - `row_i`=12..15 is never asserted.
- **Bell**: pulse `bell_i` 0→1 with BELL_HALF=4, BELL_FRAMES=3.
  - `bell_o` is a square wave of period 8 clocks, starting 2 clocks after the edge.
  - `bell_act_o` drops after the 3rd `frame_i`.
  - Holding `bell_i`=1 produces no second ring.
- **Retrigger and collisions**:
  - A new rising edge of `bell_i` on the same cycle as the final `frame_i` extends the ring by 3 more frames.
  - `wb_rst_n` low mid-ring clears `bell_o` and `bell_act_o` asynchronously.
